// File: rtl/ternary_pe_cluster_db_if.sv
// Weight-load and bank-swap handshake bundle for ternary_pe_cluster_db.
interface ternary_pe_cluster_db_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) ();
    logic                    wl_valid;
    logic                    wl_ready;
    logic [$clog2(ROWS)-1:0] wl_row;
    logic [2*COLS-1:0]       wl_weights;
    logic                    swap_req;
    logic                    swap_ack;
    logic                    bank_sel;
    logic                    shadow_full;

    modport master (
        output wl_valid, wl_row, wl_weights, swap_req,
        input  wl_ready, swap_ack, bank_sel, shadow_full
    );

    modport slave (
        input  wl_valid, wl_row, wl_weights, swap_req,
        output wl_ready, swap_ack, bank_sel, shadow_full
    );
endinterface

// File: rtl/ternary_pe_cluster_db.sv
// ROWS x COLS ternary weight-stationary PE cluster with active/shadow weight
// banks, bank-swap handshake, saturating zero-skip counter and illegal flag.
module ternary_pe_cluster_db #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ACT_BITS = 16,
    parameter int ACC_BITS = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    ternary_pe_cluster_db_if.slave   wl_if,
    input  logic [ROWS*ACT_BITS-1:0] act_in,
    output logic [ROWS*ACT_BITS-1:0] act_out,
    input  logic [COLS*ACC_BITS-1:0] psum_in,
    output logic [COLS*ACC_BITS-1:0] psum_out,
    input  logic                     clear_count,
    output logic [CNT_BITS-1:0]      zero_skip_count,
    output logic                     count_sat,
    output logic                     illegal_weight
);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int SUM_W  = $clog2(ROWS*COLS+1);
    localparam int WIDE_W = ((CNT_BITS > SUM_W) ? CNT_BITS : SUM_W) + 1;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [0:0]          state;
    logic [ROWS-1:0]     row_mask;
    logic [ROWS-1:0]     mask_nxt;
    logic                bank_sel;
    logic                swap_ack;
    logic                illegal_q;
    logic                row_ok;
    logic                wr_en;
    logic                has_illegal;
    logic [1:0]          bank [2][ROWS][COLS];
    logic [ACT_BITS-1:0] act_q  [ROWS][COLS];
    logic [ACC_BITS-1:0] psum_q [ROWS][COLS];
    logic [SUM_W-1:0]    zero_pes;
    logic [WIDE_W-1:0]   cnt_sum;
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] cnt_next;

    if (ROWS == (1 << ROW_W)) begin : g_row_pow2
        assign row_ok = 1'b1;
    end else begin : g_row_chk
        assign row_ok = (32'(wl_if.wl_row) < 32'(ROWS));
    end

    assign wl_if.wl_ready    = (state == FILL);
    assign wl_if.shadow_full = (state == READY);
    assign wl_if.swap_ack    = swap_ack;
    assign wl_if.bank_sel    = bank_sel;
    assign illegal_weight    = illegal_q;

    assign wr_en = wl_if.wl_valid & (state == FILL) & row_ok;

    // Mask as it will look after this cycle's write.
    always_comb begin
        mask_nxt = row_mask;
        if (wr_en) mask_nxt[wl_if.wl_row] = 1'b1;
    end

    // Detect any 11 code in the incoming row.
    always_comb begin
        has_illegal = 1'b0;
        for (int unsigned c = 0; c < COLS; c++)
            if (wl_if.wl_weights[2*c +: 2] == 2'b11) has_illegal = 1'b1;
    end

    // Load/swap control: FILL collects rows, READY waits for swap_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            row_mask  <= '0;
            bank_sel  <= 1'b0;
            swap_ack  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (state == READY) begin
                if (wl_if.swap_req) begin
                    bank_sel <= ~bank_sel;
                    row_mask <= '0;
                    swap_ack <= 1'b1;
                    state    <= FILL;
                end
            end else begin
                row_mask <= mask_nxt;
                if (&mask_nxt) state <= READY;
            end
            if (wr_en && has_illegal) illegal_q <= 1'b1;
        end
    end

    // Weight banks: reset to all-zero code, writes land only in the shadow bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned r = 0; r < ROWS; r++)
                    for (int unsigned c = 0; c < COLS; c++)
                        bank[b][r][c] <= 2'b01;
        end else if (wr_en) begin
            for (int unsigned c = 0; c < COLS; c++)
                bank[~bank_sel][wl_if.wl_row][c] <= wl_if.wl_weights[2*c +: 2];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [ACT_BITS-1:0] a_src;
            logic [ACC_BITS-1:0] p_src;
            logic [ACC_BITS-1:0] a_ext;
            logic [1:0]          w;

            if (c == 0) begin : g_west
                assign a_src = act_in[r*ACT_BITS +: ACT_BITS];
            end else begin : g_inner_a
                assign a_src = act_q[r][c-1];
            end
            if (r == 0) begin : g_north
                assign p_src = psum_in[c*ACC_BITS +: ACC_BITS];
            end else begin : g_inner_p
                assign p_src = psum_q[r-1][c];
            end

            assign w     = bank[bank_sel][r][c];
            assign a_ext = {{(ACC_BITS-ACT_BITS){a_src[ACT_BITS-1]}}, a_src};

            // One PE: forward activation east, add/sub/pass partial sum south.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    act_q[r][c]  <= '0;
                    psum_q[r][c] <= '0;
                end else if (enable) begin
                    act_q[r][c] <= a_src;
                    case (w)
                        2'b10:   psum_q[r][c] <= p_src + a_ext;
                        2'b00:   psum_q[r][c] <= p_src - a_ext;
                        default: psum_q[r][c] <= p_src;
                    endcase
                end
            end
        end
        assign act_out[r*ACT_BITS +: ACT_BITS] = act_q[r][COLS-1];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_south
        assign psum_out[c*ACC_BITS +: ACC_BITS] = psum_q[ROWS-1][c];
    end

    // Count active-bank PEs holding 01 or 11 (both have bit 0 set).
    always_comb begin
        zero_pes = '0;
        for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
                zero_pes = zero_pes + SUM_W'(bank[bank_sel][r][c][0]);
    end

    assign cnt_sum  = WIDE_W'(count_q) + WIDE_W'(zero_pes);
    assign cnt_next = (cnt_sum[WIDE_W-1:CNT_BITS] != '0) ? '1 : cnt_sum[CNT_BITS-1:0];

    // Zero-skip counter: clear wins over increment, clear ignores enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              count_q <= '0;
        else if (clear_count) count_q <= '0;
        else if (enable)      count_q <= cnt_next;
    end

    assign zero_skip_count = count_q;
    assign count_sat       = (count_q == '1);
endmodule

// File: tb/tb_ternary_pe_cluster_db.sv
// Directed self-checking bench for ternary_pe_cluster_db (8x8 default build).
module tb_ternary_pe_cluster_db;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int AB   = 16;
    localparam int CB   = 32;
    localparam int NB   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [ROWS*AB-1:0] act_in;
    logic [ROWS*AB-1:0] act_out;
    logic [COLS*CB-1:0] psum_in;
    logic [COLS*CB-1:0] psum_out;
    logic             clear_count;
    logic [NB-1:0]    zero_skip_count;
    logic             count_sat;
    logic             illegal_weight;

    int checks   = 0;
    int failures = 0;

    ternary_pe_cluster_db_if #(.ROWS(ROWS), .COLS(COLS)) wl_if ();

    ternary_pe_cluster_db #(
        .ROWS(ROWS), .COLS(COLS), .ACT_BITS(AB), .ACC_BITS(CB), .CNT_BITS(NB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wl_if(wl_if),
        .act_in(act_in),
        .act_out(act_out),
        .psum_in(psum_in),
        .psum_out(psum_out),
        .clear_count(clear_count),
        .zero_skip_count(zero_skip_count),
        .count_sat(count_sat),
        .illegal_weight(illegal_weight)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_row(input int r, input logic [2*COLS-1:0] w);
        wl_if.wl_valid   = 1'b1;
        wl_if.wl_row     = 3'(r);
        wl_if.wl_weights = w;
        @(negedge clk);
        wl_if.wl_valid   = 1'b0;
    endtask

    task automatic set_act_all(input int v);
        for (int r = 0; r < ROWS; r++) act_in[r*AB +: AB] = 16'(v);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bank_sel"}, 64'(wl_if.bank_sel), 64'd0);
        check({tag, "_shadow_full"}, 64'(wl_if.shadow_full), 64'd0);
        check({tag, "_wl_ready"}, 64'(wl_if.wl_ready), 64'd1);
        check({tag, "_swap_ack"}, 64'(wl_if.swap_ack), 64'd0);
        check({tag, "_count"}, 64'(zero_skip_count), 64'd0);
        check({tag, "_count_sat"}, 64'(count_sat), 64'd0);
        check({tag, "_illegal"}, 64'(illegal_weight), 64'd0);
        check({tag, "_act_out"}, 64'(act_out), 64'd0);
        check({tag, "_psum_out"}, 64'(psum_out), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*COLS-1:0] w;

        rst = 1'b1; enable = 1'b0; clear_count = 1'b0;
        act_in = '0; psum_in = '0;
        wl_if.wl_valid = 1'b0; wl_if.wl_row = '0; wl_if.wl_weights = '0; wl_if.swap_req = 1'b0;
        tick(2);
        check_reset_state("rst0");

        // Default weights are all zero-code: psum stays 0, counter +64/cycle.
        rst = 1'b0; enable = 1'b1; set_act_all(5);
        tick(1); check("cnt_1", 64'(zero_skip_count), 64'd64);
        tick(1); check("cnt_2", 64'(zero_skip_count), 64'd128);
        tick(1021);
        check("cnt_1023", 64'(zero_skip_count), 64'd65472);
        check("sat_1023", 64'(count_sat), 64'd0);
        tick(1);
        check("cnt_sat", 64'(zero_skip_count), 64'd65535);
        check("sat_1024", 64'(count_sat), 64'd1);
        tick(1);
        check("cnt_hold_sat", 64'(zero_skip_count), 64'd65535);
        check("psum_default_c0", 64'(psum_out[0 +: CB]), 64'd0);
        check("psum_default_c7", 64'(psum_out[7*CB +: CB]), 64'd0);
        check("act_out_r3", 64'(act_out[3*AB +: AB]), 64'd5);
        clear_count = 1'b1; tick(1); clear_count = 1'b0;
        check("cnt_clear_en", 64'(zero_skip_count), 64'd0);

        // All +1 tile, swap, act=3 -> every column sums 8*3.
        set_act_all(3);
        for (int r = 0; r < 7; r++) write_row(r, 16'hAAAA);
        check("full_after7", 64'(wl_if.shadow_full), 64'd0);
        check("ready_after7", 64'(wl_if.wl_ready), 64'd1);
        write_row(7, 16'hAAAA);
        check("full_after8", 64'(wl_if.shadow_full), 64'd1);
        check("ready_after8", 64'(wl_if.wl_ready), 64'd0);
        check("bank_before_swap", 64'(wl_if.bank_sel), 64'd0);
        wl_if.swap_req = 1'b1; tick(1); wl_if.swap_req = 1'b0;
        check("swap_ack", 64'(wl_if.swap_ack), 64'd1);
        check("bank_after_swap", 64'(wl_if.bank_sel), 64'd1);
        check("full_after_swap", 64'(wl_if.shadow_full), 64'd0);
        tick(1);
        check("swap_ack_pulse", 64'(wl_if.swap_ack), 64'd0);
        clear_count = 1'b1; tick(1); clear_count = 1'b0;
        tick(3);
        check("cnt_no_zero_pes", 64'(zero_skip_count), 64'd0);
        tick(16);
        for (int c = 0; c < COLS; c++)
            check($sformatf("psum_plus_c%0d", c), 64'(psum_out[c*CB +: CB]), 64'd24);

        // Diagonal -1, rest +1, act[r]=r+1 -> 36 - 2(c+1).
        for (int r = 0; r < ROWS; r++) act_in[r*AB +: AB] = 16'(r + 1);
        for (int r = 0; r < ROWS; r++) begin
            w = 16'hAAAA;
            w[2*r +: 2] = 2'b00;
            write_row(r, w);
        end
        wl_if.swap_req = 1'b1; tick(1); wl_if.swap_req = 1'b0;
        check("swap2_bank", 64'(wl_if.bank_sel), 64'd0);
        tick(20);
        for (int c = 0; c < COLS; c++)
            check($sformatf("psum_diag_c%0d", c), 64'(psum_out[c*CB +: CB]), 64'(36 - 2*(c + 1)));

        // swap_req held across partial load; row 0 carries an illegal code.
        wl_if.swap_req = 1'b1;
        write_row(0, 16'h5557);
        check("illegal_set", 64'(illegal_weight), 64'd1);
        for (int r = 1; r < 7; r++) begin
            write_row(r, 16'h5555);
            check($sformatf("no_ack_row%0d", r), 64'(wl_if.swap_ack), 64'd0);
        end
        write_row(7, 16'h5555);
        check("full_final_row", 64'(wl_if.shadow_full), 64'd1);
        check("no_ack_final_row", 64'(wl_if.swap_ack), 64'd0);
        check("bank_final_row", 64'(wl_if.bank_sel), 64'd0);
        tick(1);
        wl_if.swap_req = 1'b0;
        check("ack_after_full", 64'(wl_if.swap_ack), 64'd1);
        check("bank_after_full", 64'(wl_if.bank_sel), 64'd1);

        // New tile: 63 zero codes + one illegal code all count as skips.
        clear_count = 1'b1; tick(1); clear_count = 1'b0;
        check("cnt_clear2", 64'(zero_skip_count), 64'd0);
        for (int c = 0; c < COLS; c++) psum_in[c*CB +: CB] = 32'(1000 + c);
        tick(1);
        check("cnt_illegal_counts", 64'(zero_skip_count), 64'd64);
        tick(12);
        for (int c = 0; c < COLS; c++)
            check($sformatf("psum_pass_c%0d", c), 64'(psum_out[c*CB +: CB]), 64'(1000 + c));

        // enable=0 freezes datapath and counter; clear still works.
        enable = 1'b0; psum_in = '0;
        tick(3);
        check("hold_psum_c0", 64'(psum_out[0 +: CB]), 64'd1000);
        check("hold_cnt", 64'(zero_skip_count), 64'd832);
        check("illegal_sticky", 64'(illegal_weight), 64'd1);
        clear_count = 1'b1; tick(1); clear_count = 1'b0;
        check("cnt_clear_noen", 64'(zero_skip_count), 64'd0);
        enable = 1'b1;
        tick(2);

        // Asynchronous reset in the middle of a load.
        for (int r = 0; r < 4; r++) write_row(r, 16'hAAAA);
        #2 rst = 1'b1;
        #1 check_reset_state("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        check("cnt_after_rst", 64'(zero_skip_count), 64'd64);
        for (int r = 4; r < ROWS; r++) write_row(r, 16'hAAAA);
        check("mask_cleared", 64'(wl_if.shadow_full), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
